instr_sequencer: RTL

Multi-cycle sequencer that drives the single-cycle datapath (decoder, register memory, ALU) from one shared single-port main memory. It owns the PC and fetches each instruction into a holding register. It arbitrates the memory port between instruction fetch and load/store. It pulses a one-cycle commit that gates register writes.

---
 rtl/instr_sequencer_pkg.sv | 20 ++
 rtl/instr_sequencer_mem_port_mux.sv | 45 ++++
 rtl/instr_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared state encodings and constants for the instruction sequencer
package instr_sequencer_pkg;

    typedef enum logic [2:0] {
        SEQ_FETCH     = 3'd0,
        SEQ_DECODE    = 3'd1,
        SEQ_MEM       = 3'd2,
        SEQ_WRITEBACK = 3'd3,
        SEQ_HALT      = 3'd4
    } seq_state_e;

    localparam logic [6:0]  OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0]  OPCODE_STORE = 7'b0100011;
    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;

    function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/instr_sequencer_mem_port_mux.sv
// rtl/instr_sequencer_mem_port_mux.sv - selects fetch or load/store fields onto the shared memory port
module seq_mem_port_mux
    import instr_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            port_en,
    input  seq_state_e      state,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] dp_mem_addr,
    input  logic [XLEN-1:0] dp_mem_wdata,
    input  logic            dp_is_store,
    input  logic [2:0]      funct3,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [2:0]      mem_wmode
);

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmode = 3'b000;
        if (port_en) begin
            case (state)
                SEQ_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = pc;
                end
                SEQ_MEM: begin
                    mem_req   = 1'b1;
                    mem_we    = dp_is_store;
                    mem_addr  = dp_mem_addr;
                    mem_wdata = dp_mem_wdata;
                    mem_wmode = funct3;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/decode/mem/writeback sequencer over one shared memory port
// Optional SEQ_PERF_COUNTERS_EN adds cycle_count and retired_count outputs.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [2:0]      mem_wmode,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic [31:0]     dp_instruction,
    output logic [XLEN-1:0] dp_pc_next,
    output logic [XLEN-1:0] dp_load_data,
    output logic            dp_commit,
    input  logic [XLEN-1:0] dp_mem_addr,
    input  logic [XLEN-1:0] dp_mem_wdata,
    input  logic            dp_is_load,
    input  logic            dp_is_store,
    input  logic            dp_take_target,
    input  logic [XLEN-1:0] dp_pc_target,
    output logic [XLEN-1:0] pc,
    output logic            trap
`ifdef SEQ_PERF_COUNTERS_EN
    ,
    output logic [63:0]     cycle_count,
    output logic [63:0]     retired_count
`endif
);

    seq_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] load_q, load_d;
    logic            trap_q, trap_d;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_new;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign pc_new   = dp_take_target ? dp_pc_target : pc_plus4;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        load_d    = load_q;
        trap_d    = trap_q;
        dp_commit = 1'b0;
        case (state_q)
            SEQ_FETCH: begin
                if (mem_ready) begin
                    instr_d = mem_rdata[31:0];
                    state_d = SEQ_DECODE;
                end
            end
            SEQ_DECODE: begin
                state_d = (dp_is_load || dp_is_store) ? SEQ_MEM : SEQ_WRITEBACK;
            end
            SEQ_MEM: begin
                if (mem_ready) begin
                    // A simultaneous load/store decode resolves as a store: no load capture.
                    if (dp_is_load && !dp_is_store) begin
                        load_d = mem_rdata;
                    end
                    state_d = SEQ_WRITEBACK;
                end
            end
            SEQ_WRITEBACK: begin
                dp_commit = !reset;
                pc_d      = pc_new;
                if (pc_misaligned(pc_new[1:0])) begin
                    trap_d  = 1'b1;
                    state_d = SEQ_HALT;
                end else begin
                    state_d = SEQ_FETCH;
                end
            end
            SEQ_HALT: ;
            default: state_d = SEQ_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEQ_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= INSTR_NOP;
            load_q  <= '0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            load_q  <= load_d;
            trap_q  <= trap_d;
        end
    end

    // Port is held idle while reset is asserted so an in-flight request drops immediately.
    seq_mem_port_mux #(
        .XLEN(XLEN)
    ) u_port_mux (
        .port_en      (!reset),
        .state        (state_q),
        .pc           (pc_q),
        .dp_mem_addr  (dp_mem_addr),
        .dp_mem_wdata (dp_mem_wdata),
        .dp_is_store  (dp_is_store),
        .funct3       (instr_q[14:12]),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wmode    (mem_wmode)
    );

    assign dp_instruction = instr_q;
    assign dp_pc_next     = pc_plus4;
    assign dp_load_data   = load_q;
    assign pc             = pc_q;
    assign trap           = trap_q;

`ifdef SEQ_PERF_COUNTERS_EN
    logic [63:0] cycle_count_q, cycle_count_d;
    logic [63:0] retired_count_q, retired_count_d;

    always_comb begin
        cycle_count_d   = cycle_count_q + 64'd1;
        retired_count_d = retired_count_q + (dp_commit ? 64'd1 : 64'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count_q   <= '0;
            retired_count_q <= '0;
        end else begin
            cycle_count_q   <= cycle_count_d;
            retired_count_q <= retired_count_d;
        end
    end

    assign cycle_count   = cycle_count_q;
    assign retired_count = retired_count_q;
`endif

endmodule
